// File: rtl/ucie_clk_pkg.sv
// Shared definitions for the forwarded-clock pattern generator:
// FSM state encoding, default burst shape and detector pass threshold.
package ucie_clk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2,
      ST_DONE   = 2'd3
   } clk_pattern_state_e;

   localparam int CLK_PATTERN_ITERATIONS = 128;
   localparam int CLK_PATTERN_ACTIVE     = 16;
   localparam int CLK_PATTERN_IDLE       = 8;

   // Far-end detector declares the clock good after this many clean bursts in a row
   localparam int CLK_DETECT_PASS_ITERATIONS = 16;

   localparam int CYCLE_CNT_W = 5;
   localparam int ITER_CNT_W  = 8;

endpackage

// File: rtl/clk_pattern_counter.sv
// Loadable cycle counter shared by the ACTIVE and GAP phases.
// Clear has priority over increment; terminal flags count == runtime limit.
module clk_pattern_counter import ucie_clk_pkg::*; #(
   parameter int WIDTH = CYCLE_CNT_W
) (
   input  logic             i_half_pll_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   input  logic [WIDTH-1:0] i_limit,
   output logic [WIDTH-1:0] o_count,
   output logic             o_terminal
);

   // Count cycles within the current phase, restarting from zero on clear
   always_ff @(posedge i_half_pll_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= '0;
      end else if (i_clear) begin
         o_count <= '0;
      end else if (i_inc) begin
         o_count <= o_count + 1'b1;
      end
   end

   assign o_terminal = (o_count == i_limit);

endmodule

// File: rtl/clk_pattern_gen.sv
// Forwarded-clock training pattern generator: bursts of ACTIVE_CYCLES enabled
// clocks separated by IDLE_CYCLES gated-low clocks, NUM_ITERATIONS times.
// All outputs are flops so the ICG enable is glitch-free.
// Optional macro CLK_PATTERN_FREERUN_EN adds i_free_run, which keeps the
// clock enabled while the FSM sits in IDLE (mainband data phase).
module clk_pattern_gen import ucie_clk_pkg::*; #(
   parameter int NUM_ITERATIONS = CLK_PATTERN_ITERATIONS,
   parameter int ACTIVE_CYCLES  = CLK_PATTERN_ACTIVE,
   parameter int IDLE_CYCLES    = CLK_PATTERN_IDLE
) (
   input  logic                  i_half_pll_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start_clk_training,
`ifdef CLK_PATTERN_FREERUN_EN
   input  logic                  i_free_run,
`endif
   output logic                  o_clk_en,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ITER_CNT_W-1:0] o_iteration
);

   localparam logic [CYCLE_CNT_W-1:0] ACTIVE_LAST = CYCLE_CNT_W'(ACTIVE_CYCLES - 1);
   localparam logic [CYCLE_CNT_W-1:0] GAP_LAST    = CYCLE_CNT_W'(IDLE_CYCLES - 1);
   localparam logic [ITER_CNT_W-1:0]  ITER_TARGET = ITER_CNT_W'(NUM_ITERATIONS);

   clk_pattern_state_e    state_q;
   clk_pattern_state_e    state_d;
   logic                  cnt_clear;
   logic                  cnt_inc;
   logic [CYCLE_CNT_W-1:0] cnt_limit;
   logic [CYCLE_CNT_W-1:0] cycle_cnt;
   logic                  cnt_terminal;
   logic [ITER_CNT_W-1:0] iteration_d;
   logic                  free_run_req;

`ifdef CLK_PATTERN_FREERUN_EN
   assign free_run_req = i_free_run;
`else
   assign free_run_req = 1'b0;
`endif

   // The counter compares against the length of whichever phase is running
   assign cnt_limit = (state_q == ST_GAP) ? GAP_LAST : ACTIVE_LAST;

   clk_pattern_counter #(
      .WIDTH (CYCLE_CNT_W)
   ) u_cycle_counter (
      .i_half_pll_clk (i_half_pll_clk),
      .i_rst_n        (i_rst_n),
      .i_clear        (cnt_clear),
      .i_inc          (cnt_inc),
      .i_limit        (cnt_limit),
      .o_count        (cycle_cnt),
      .o_terminal     (cnt_terminal)
   );

   // Next state, counter control and burst count; dropping start aborts to IDLE
   always_comb begin
      state_d     = state_q;
      iteration_d = o_iteration;
      cnt_clear   = 1'b1;
      cnt_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start_clk_training) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (!i_start_clk_training) begin
               state_d = ST_IDLE;
            end else if (cnt_terminal) begin
               state_d     = ST_GAP;
               iteration_d = o_iteration + 1'b1;
            end else begin
               cnt_clear = 1'b0;
               cnt_inc   = 1'b1;
            end
         end
         ST_GAP: begin
            if (!i_start_clk_training) begin
               state_d = ST_IDLE;
            end else if (cnt_terminal) begin
               state_d = (o_iteration == ITER_TARGET) ? ST_DONE : ST_ACTIVE;
            end else begin
               cnt_clear = 1'b0;
               cnt_inc   = 1'b1;
            end
         end
         ST_DONE: begin
            if (!i_start_clk_training) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d == ST_IDLE) begin
         iteration_d = '0;
      end
   end

   // State and outputs are registered from the next state so every output is a clean flop
   always_ff @(posedge i_half_pll_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         o_clk_en    <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_iteration <= '0;
      end else begin
         state_q     <= state_d;
         o_clk_en    <= (state_d == ST_ACTIVE) || ((state_d == ST_IDLE) && free_run_req);
         o_busy      <= (state_d == ST_ACTIVE) || (state_d == ST_GAP);
         o_done      <= (state_d == ST_DONE);
         o_iteration <= iteration_d;
      end
   end

endmodule

// File: tb/tb_clk_pattern_gen.sv
// Directed bench for clk_pattern_gen: default-shape run, hold after done,
// abort mid-burst, async reset mid-gap, minimal parameter set and
// (when CLK_PATTERN_FREERUN_EN is defined) free-run behaviour.
module tb_clk_pattern_gen;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       start_s;
`ifdef CLK_PATTERN_FREERUN_EN
   logic       free_run;
`endif

   logic       clk_en;
   logic       busy;
   logic       done;
   logic [7:0] iteration;

   logic       clk_en_s;
   logic       busy_s;
   logic       done_s;
   logic [7:0] iteration_s;

   int tests_run;
   int tests_failed;

   localparam int RUN_LEN = 128 * (16 + 8);

   clk_pattern_gen u_dut (
      .i_half_pll_clk       (clk),
      .i_rst_n              (rst_n),
      .i_start_clk_training (start),
`ifdef CLK_PATTERN_FREERUN_EN
      .i_free_run           (free_run),
`endif
      .o_clk_en             (clk_en),
      .o_busy               (busy),
      .o_done               (done),
      .o_iteration          (iteration)
   );

   clk_pattern_gen #(
      .NUM_ITERATIONS (1),
      .ACTIVE_CYCLES  (2),
      .IDLE_CYCLES    (1)
   ) u_small (
      .i_half_pll_clk       (clk),
      .i_rst_n              (rst_n),
      .i_start_clk_training (start_s),
`ifdef CLK_PATTERN_FREERUN_EN
      .i_free_run           (1'b0),
`endif
      .o_clk_en             (clk_en_s),
      .o_busy               (busy_s),
      .o_done               (done_s),
      .o_iteration          (iteration_s)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected {clk_en, busy, done, iteration} c cycles after start was sampled, default shape
   function automatic logic [10:0] exp_default(input int c);
      int p;
      int it;
      if (c >= RUN_LEN) begin
         return {1'b0, 1'b0, 1'b1, 8'd128};
      end
      p  = c % 24;
      it = (c / 24) + ((p >= 16) ? 1 : 0);
      return {(p < 16), 1'b1, 1'b0, 8'(it)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      start   = 1'b0;
      start_s = 1'b0;
      rst_n   = 1'b0;
      #12;
      tests_run++;
      if ({clk_en, busy, done, iteration} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_main: got %b/%b/%b/%0d expected 0/0/0/0", clk_en, busy, done, iteration);
      end
      tests_run++;
      if ({clk_en_s, busy_s, done_s, iteration_s} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_small: got %b/%b/%b/%0d expected 0/0/0/0", clk_en_s, busy_s, done_s, iteration_s);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      tests_run++;
      if ({clk_en, busy, done, iteration} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL idle_after_reset: got %b/%b/%b/%0d expected 0/0/0/0", clk_en, busy, done, iteration);
      end
   endtask

   task automatic test_full_run();
      logic [10:0] expv;
      start = 1'b1;
      tick();
      for (int c = 0; c <= RUN_LEN; c++) begin
         expv = exp_default(c);
         tests_run++;
         if ({clk_en, busy, done, iteration} !== expv) begin
            tests_failed++;
            $display("[TB] FAIL full_run c=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     c, clk_en, busy, done, iteration, expv[10], expv[9], expv[8], expv[7:0]);
         end
         if (c < RUN_LEN) tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] expv;
      for (int i = 0; i < 50; i++) begin
         tick();
         tests_run++;
         if ({clk_en, busy, done, iteration} !== {1'b0, 1'b0, 1'b1, 8'd128}) begin
            tests_failed++;
            $display("[TB] FAIL hold_done i=%0d: got %b/%b/%b/%0d expected 0/0/1/128", i, clk_en, busy, done, iteration);
         end
      end
      start = 1'b0;
      tick();
      tests_run++;
      if ({clk_en, busy, done, iteration} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL done_release: got %b/%b/%b/%0d expected 0/0/0/0", clk_en, busy, done, iteration);
      end
      start = 1'b1;
      tick();
      tests_run++;
      if ({clk_en, busy, done, iteration} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
         tests_failed++;
         $display("[TB] FAIL restart: got %b/%b/%b/%0d expected 1/1/0/0", clk_en, busy, done, iteration);
      end
      // Carry on into the abort scenario: burst 5, 8th ACTIVE cycle is c = 4*24 + 7
      for (int c = 1; c <= 103; c++) begin
         tick();
         expv = exp_default(c);
         tests_run++;
         if ({clk_en, busy, done, iteration} !== expv) begin
            tests_failed++;
            $display("[TB] FAIL pre_abort c=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     c, clk_en, busy, done, iteration, expv[10], expv[9], expv[8], expv[7:0]);
         end
      end
   endtask

   task automatic test_abort();
      start = 1'b0;
      tick();
      tests_run++;
      if ({clk_en, busy} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL abort_edge: got clk_en=%b busy=%b expected 0/0", clk_en, busy);
      end
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if ({clk_en, busy, done, iteration} !== 11'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle i=%0d: got %b/%b/%b/%0d expected 0/0/0/0", i, clk_en, busy, done, iteration);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      logic [10:0] expv;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 20; c++) tick();
      tests_run++;
      if ({clk_en, busy, iteration} !== {1'b0, 1'b1, 8'd1}) begin
         tests_failed++;
         $display("[TB] FAIL in_gap: got clk_en=%b busy=%b iter=%0d expected 0/1/1", clk_en, busy, iteration);
      end
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({clk_en, busy, done, iteration} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got %b/%b/%b/%0d expected 0/0/0/0", clk_en, busy, done, iteration);
      end
      #1;
      rst_n = 1'b1;
      tick();
      for (int c = 0; c <= RUN_LEN; c++) begin
         expv = exp_default(c);
         tests_run++;
         if ({clk_en, busy, done, iteration} !== expv) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_run c=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     c, clk_en, busy, done, iteration, expv[10], expv[9], expv[8], expv[7:0]);
         end
         if (c < RUN_LEN) tick();
      end
   endtask

   task automatic test_small_params();
      logic [10:0] table_v [0:5];
      table_v[0] = {1'b1, 1'b1, 1'b0, 8'd0};
      table_v[1] = {1'b1, 1'b1, 1'b0, 8'd0};
      table_v[2] = {1'b0, 1'b1, 1'b0, 8'd1};
      table_v[3] = {1'b0, 1'b0, 1'b1, 8'd1};
      table_v[4] = {1'b0, 1'b0, 1'b1, 8'd1};
      table_v[5] = {1'b0, 1'b0, 1'b1, 8'd1};
      start_s = 1'b1;
      tick();
      for (int c = 0; c < 6; c++) begin
         tests_run++;
         if ({clk_en_s, busy_s, done_s, iteration_s} !== table_v[c]) begin
            tests_failed++;
            $display("[TB] FAIL small c=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     c, clk_en_s, busy_s, done_s, iteration_s,
                     table_v[c][10], table_v[c][9], table_v[c][8], table_v[c][7:0]);
         end
         tick();
      end
      start_s = 1'b0;
      tick();
      tests_run++;
      if ({clk_en_s, busy_s, done_s, iteration_s} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL small_release: got %b/%b/%b/%0d expected 0/0/0/0", clk_en_s, busy_s, done_s, iteration_s);
      end
   endtask

`ifdef CLK_PATTERN_FREERUN_EN
   task automatic test_free_run();
      logic [10:0] expv;
      free_run = 1'b1;
      start    = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if ({clk_en, busy, done, iteration} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("[TB] FAIL free_idle i=%0d: got %b/%b/%b/%0d expected 1/0/0/0", i, clk_en, busy, done, iteration);
         end
         tick();
      end
      start = 1'b1;
      tick();
      for (int c = 0; c <= RUN_LEN; c++) begin
         expv = exp_default(c);
         tests_run++;
         if ({clk_en, busy, done, iteration} !== expv) begin
            tests_failed++;
            $display("[TB] FAIL free_run_pattern c=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     c, clk_en, busy, done, iteration, expv[10], expv[9], expv[8], expv[7:0]);
         end
         if (c < RUN_LEN) tick();
      end
      start = 1'b0;
      tick();
      tests_run++;
      if ({clk_en, busy, done, iteration} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         tests_failed++;
         $display("[TB] FAIL free_return: got %b/%b/%b/%0d expected 1/0/0/0", clk_en, busy, done, iteration);
      end
      free_run = 1'b0;
   endtask
`endif

   // Scenario sequence
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b1;
      start        = 1'b0;
      start_s      = 1'b0;
`ifdef CLK_PATTERN_FREERUN_EN
      free_run     = 1'b0;
`endif
      test_reset();
      test_full_run();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_small_params();
`ifdef CLK_PATTERN_FREERUN_EN
      test_free_run();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
